// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// The magnitude helper works at the widest supported width so one definition serves every WIDTH.
package mult_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    // Returns |x| for a width-bit operand when signed_mode is set, otherwise x unchanged.
    // The most negative value maps to 2^(width-1), which still fits unsigned in width bits.
    function automatic logic [MAX_WIDTH-1:0] magnitude(
        input logic [MAX_WIDTH-1:0] x,
        input int                   width,
        input logic                 signed_mode
    );
        logic [MAX_WIDTH-1:0] mask;
        logic                 msb;
        mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
        msb  = ((x >> (width - 1)) & MAX_WIDTH'(1)) != '0;
        if (signed_mode && msb) begin
            return (~x + MAX_WIDTH'(1)) & mask;
        end
        return x & mask;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between a requester and the sequential multiplier.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier_datapath.sv
// Accumulator, shifting multiplicand/multiplier registers and the adder.
// Works purely on unsigned magnitudes; sign handling lives in the controller.
module shift_add_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    // One multiplier bit is consumed per step; the multiplicand is pre-widened so left shifts never lose bits.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            acc_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: controller, iteration counter, sign flag and product register.
// One multiplier bit per clock, constant latency of WIDTH+1 cycles from the start edge.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_multiplier_if.slave   bus
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("seq_multiplier: WIDTH must be within 2..32");
    end

    localparam int              CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);

    state_t               state_q;
    logic [CW-1:0]        count_q;
    logic                 neg_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 load;
    logic                 step;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;

    assign load  = (state_q == IDLE) && bus.start;
    assign step  = (state_q == CALC);
    assign mag_a = WIDTH'(magnitude(MAX_WIDTH'(bus.a), WIDTH, bus.signed_mode));
    assign mag_b = WIDTH'(magnitude(MAX_WIDTH'(bus.b), WIDTH, bus.signed_mode));

    shift_add_datapath #(
        .WIDTH    (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (mag_a),
        .mplier_i (mag_b),
        .acc_o    (acc)
    );

    // FIX exists so the final accumulation settles before the optional negation is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        neg_q   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    product_q <= neg_q ? (~acc + 1'b1) : acc;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
